// File: rtl/perceptron_train_sequencer.sv
// perceptron_train_sequencer
// Sequences perceptron training: walks NUM samples per epoch for a latched
// number of epochs, requests a forward pass per sample, forms the error
// (expected - prediction) and requests a weight update only when it is nonzero.
// Optional feature macro: PERCEPTRON_EARLY_STOP_EN -- finish as soon as an
// epoch completes with zero errors.
module perceptron_train_sequencer #(
   parameter int NUM     = 4,
   parameter int EPOCH_W = 16,
   parameter int SFP_W   = 32,
   localparam int IDX_W  = $clog2(NUM)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [EPOCH_W-1:0] epochs,
   output logic [IDX_W-1:0]   sample_idx,
   output logic               fwd_valid,
   input  logic               fwd_ready,
   input  logic               pred_valid,
   input  logic [SFP_W-1:0]   prediction,
   input  logic [SFP_W-1:0]   expected,
   output logic               upd_valid,
   input  logic               upd_ready,
   output logic [SFP_W-1:0]   error,
   output logic               busy,
   output logic               done,
   output logic               converged,
   output logic [EPOCH_W-1:0] epoch_count,
   output logic [IDX_W:0]     err_count
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_PRED,
      UPDATE,
      NEXT,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM - 1);
   localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
   localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);
   localparam logic [IDX_W:0]     ERR_ONE   = (IDX_W + 1)'(1);

   state_t             state;
   logic [EPOCH_W-1:0] epochs_q;
   logic [SFP_W-1:0]   diff;
   logic               epoch_last;

   // Error of the current sample; plain two's-complement wrap.
   always_comb begin
      diff = expected - prediction;
   end

   // Decide whether the epoch now ending is the final one.
   always_comb begin
      epoch_last = ((epoch_count + EPOCH_ONE) == epochs_q);
`ifdef PERCEPTRON_EARLY_STOP_EN
      epoch_last = epoch_last || (err_count == '0);
`endif
   end

   // Training FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         epochs_q    <= '0;
         sample_idx  <= '0;
         fwd_valid   <= 1'b0;
         upd_valid   <= 1'b0;
         error       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         converged   <= 1'b0;
         epoch_count <= '0;
         err_count   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  epochs_q    <= epochs;
                  epoch_count <= '0;
                  err_count   <= '0;
                  converged   <= 1'b0;
                  sample_idx  <= '0;
                  if (epochs == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state     <= ISSUE;
                     fwd_valid <= 1'b1;
                     busy      <= 1'b1;
                     done      <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               if (fwd_ready) begin
                  fwd_valid <= 1'b0;
                  state     <= WAIT_PRED;
               end
            end
            WAIT_PRED: begin
               if (pred_valid) begin
                  error <= diff;
                  if (diff != '0) begin
                     err_count <= err_count + ERR_ONE;
                     upd_valid <= 1'b1;
                     state     <= UPDATE;
                  end else begin
                     state <= NEXT;
                  end
               end
            end
            UPDATE: begin
               if (upd_ready) begin
                  upd_valid <= 1'b0;
                  state     <= NEXT;
               end
            end
            NEXT: begin
               if (sample_idx != LAST_IDX) begin
                  sample_idx <= sample_idx + IDX_ONE;
                  fwd_valid  <= 1'b1;
                  state      <= ISSUE;
               end else begin
                  epoch_count <= epoch_count + EPOCH_ONE;
                  converged   <= (err_count == '0);
                  err_count   <= '0;
                  sample_idx  <= '0;
                  if (epoch_last) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     fwd_valid <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Bench for perceptron_train_sequencer: a behavioural datapath drives the
// handshakes from a per-epoch prediction plan; a reference model derives the
// expected update list, epoch error counts and final status from that plan.
module tb_perceptron_train_sequencer;

   localparam int NUM     = 4;
   localparam int EPOCH_W = 16;
   localparam int SFP_W   = 32;
   localparam int IDX_W   = $clog2(NUM);
   localparam int MAXE    = 8;
   localparam logic [SFP_W-1:0] ONE = 32'h0001_0000;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [EPOCH_W-1:0] epochs;
   logic [IDX_W-1:0]   sample_idx;
   logic               fwd_valid;
   logic               fwd_ready;
   logic               pred_valid;
   logic [SFP_W-1:0]   prediction;
   logic [SFP_W-1:0]   expected;
   logic               upd_valid;
   logic               upd_ready;
   logic [SFP_W-1:0]   error;
   logic               busy;
   logic               done;
   logic               converged;
   logic [EPOCH_W-1:0] epoch_count;
   logic [IDX_W:0]     err_count;

   perceptron_train_sequencer #(.NUM(NUM), .EPOCH_W(EPOCH_W), .SFP_W(SFP_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .epochs(epochs),
      .sample_idx(sample_idx), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
      .pred_valid(pred_valid), .prediction(prediction), .expected(expected),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .error(error),
      .busy(busy), .done(done), .converged(converged),
      .epoch_count(epoch_count), .err_count(err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Training set targets and planned predictions per (epoch, sample).
   logic [SFP_W-1:0] tgt  [NUM];
   logic [SFP_W-1:0] plan [MAXE][NUM];
   assign expected = tgt[sample_idx];

   // Datapath model state and observation logs.
   int   fwd_bp, upd_bp, lat_max;
   bit   junk_en;
   int   fwd_wait_cur, fwd_hold, upd_wait_cur, upd_hold;
   bit   outstanding;
   int   pend_lat;
   logic [SFP_W-1:0] pend_pred;
   int   fwd_cnt, busy_cycles, prev_ep, prev_err;
   int   obs_fwd[$];
   int   obs_upd_idx[$];
   logic [SFP_W-1:0] obs_upd_err[$];
   int   obs_epoch_errs[$];
   bit   pf_valid, pf_acc, pu_valid, pu_acc;
   logic [IDX_W-1:0] pf_idx, pu_idx;
   logic [SFP_W-1:0] pu_err;

   function automatic int pick(input int bp);
      return (bp < 0) ? int'($urandom_range(0, 3)) : bp;
   endfunction

   // Behavioural datapath and monitors, all on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         pred_valid = 1'b0; fwd_ready = 1'b0; upd_ready = 1'b0;
         outstanding = 1'b0; pf_valid = 1'b0; pu_valid = 1'b0;
         pf_acc = 1'b0; pu_acc = 1'b0; fwd_hold = 0; upd_hold = 0;
      end else begin
         if (pf_valid && !pf_acc)
            check_eq("fwd_hold", {fwd_valid, sample_idx}, {1'b1, pf_idx});
         if (pu_valid && !pu_acc)
            check_eq("upd_hold", {upd_valid, sample_idx, error}, {1'b1, pu_idx, pu_err});
         if (int'(epoch_count) == prev_ep + 1) obs_epoch_errs.push_back(prev_err);
         prev_ep  = int'(epoch_count);
         prev_err = int'(err_count);
         if (busy) busy_cycles++;

         pred_valid = 1'b0;
         if (outstanding) begin
            if (pend_lat > 0) pend_lat--;
            else begin
               pred_valid  = 1'b1;
               prediction  = pend_pred;
               outstanding = 1'b0;
            end
         end else if (junk_en && $urandom_range(0, 5) == 0) begin
            pred_valid = 1'b1;
            prediction = $urandom;
         end

         fwd_ready = 1'b0;
         pf_acc    = 1'b0;
         if (fwd_valid) begin
            if (fwd_hold < fwd_wait_cur) fwd_hold++;
            else begin
               int ep;
               ep = fwd_cnt / NUM;
               if (ep > MAXE - 1) ep = MAXE - 1;
               fwd_ready   = 1'b1;
               pf_acc      = 1'b1;
               obs_fwd.push_back(int'(sample_idx));
               pend_pred   = plan[ep][sample_idx];
               pend_lat    = (lat_max > 0) ? int'($urandom_range(0, lat_max)) : 0;
               outstanding = 1'b1;
               fwd_cnt++;
               fwd_hold     = 0;
               fwd_wait_cur = pick(fwd_bp);
            end
         end
         pf_valid = fwd_valid;
         pf_idx   = sample_idx;

         upd_ready = 1'b0;
         pu_acc    = 1'b0;
         if (upd_valid) begin
            if (upd_hold < upd_wait_cur) upd_hold++;
            else begin
               upd_ready = 1'b1;
               pu_acc    = 1'b1;
               obs_upd_idx.push_back(int'(sample_idx));
               obs_upd_err.push_back(error);
               upd_hold     = 0;
               upd_wait_cur = pick(upd_bp);
            end
         end
         pu_valid = upd_valid;
         pu_idx   = sample_idx;
         pu_err   = error;
      end
   end

   task automatic set_plan_correct();
      for (int e = 0; e < MAXE; e++)
         for (int s = 0; s < NUM; s++) plan[e][s] = tgt[s];
   endtask

   task automatic check_reset_zero(input string tag);
      check_eq(tag, {sample_idx, fwd_valid, upd_valid, error, busy, done, converged,
                     epoch_count, err_count}, 64'd0);
   endtask

   task automatic prep(input int fbp, input int ubp, input int lmax, input bit junk);
      fwd_bp = fbp; upd_bp = ubp; lat_max = lmax; junk_en = junk;
      fwd_wait_cur = pick(fbp); upd_wait_cur = pick(ubp);
      fwd_hold = 0; upd_hold = 0; fwd_cnt = 0; busy_cycles = 0;
      prev_ep = int'(epoch_count); prev_err = 0;
      obs_fwd.delete(); obs_upd_idx.delete(); obs_upd_err.delete(); obs_epoch_errs.delete();
   endtask

   task automatic run_case(input string name, input int ep, input int fbp, input int ubp,
                           input int lmax, input bit junk, input bit timing);
      int exp_run;
      bit exp_conv;
      int exp_idx[$];
      logic [SFP_W-1:0] exp_err[$];
      int exp_eerr[$];
      bit got;
      exp_run  = 0;
      exp_conv = 1'b0;
      for (int e = 0; e < ep; e++) begin
         int n;
         n = 0;
         for (int s = 0; s < NUM; s++) begin
            logic [SFP_W-1:0] d;
            d = tgt[s] - plan[e][s];
            if (d != '0) begin
               exp_idx.push_back(s);
               exp_err.push_back(d);
               n++;
            end
         end
         exp_eerr.push_back(n);
         exp_run++;
         exp_conv = (n == 0);
`ifdef PERCEPTRON_EARLY_STOP_EN
         if (n == 0) break;
`endif
      end

      @(negedge clk); #1;
      prep(fbp, ubp, lmax, junk);
      epochs = EPOCH_W'(ep);
      start  = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      check_eq({name, ":fwd_after_start"}, {63'd0, fwd_valid}, {63'd0, ep != 0});
      check_eq({name, ":done_after_start"}, {63'd0, done}, {63'd0, ep == 0});

      got = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      check_eq({name, ":finished"}, {63'd0, got}, 64'd1);
      check_eq({name, ":epoch_count"}, 64'(epoch_count), 64'(exp_run));
      check_eq({name, ":converged"}, {63'd0, converged}, {63'd0, exp_conv});
      check_eq({name, ":busy_low"}, {63'd0, busy}, 64'd0);

      check_eq({name, ":n_updates"}, 64'(obs_upd_idx.size()), 64'(exp_idx.size()));
      for (int k = 0; k < exp_idx.size() && k < obs_upd_idx.size(); k++) begin
         check_eq({name, ":upd_idx"}, 64'(obs_upd_idx[k]), 64'(exp_idx[k]));
         check_eq({name, ":upd_err"}, 64'(obs_upd_err[k]), 64'(exp_err[k]));
      end

      check_eq({name, ":n_forward"}, 64'(obs_fwd.size()), 64'(exp_run * NUM));
      for (int k = 0; k < obs_fwd.size() && k < exp_run * NUM; k++)
         check_eq({name, ":fwd_order"}, 64'(obs_fwd[k]), 64'(k % NUM));

      check_eq({name, ":n_epochs_seen"}, 64'(obs_epoch_errs.size()), 64'(exp_eerr.size()));
      for (int k = 0; k < exp_eerr.size() && k < obs_epoch_errs.size(); k++)
         check_eq({name, ":epoch_errs"}, 64'(obs_epoch_errs[k]), 64'(exp_eerr[k]));

      if (timing)
         check_eq({name, ":busy_cycles"}, 64'(busy_cycles),
                  64'(exp_run * NUM * 3 + exp_idx.size()));

      @(negedge clk); @(negedge clk); #1;
      check_eq({name, ":done_held"}, {63'd0, done}, 64'd1);
   endtask

   initial begin
      bit hit;
      rst_n = 1'b0; start = 1'b0; epochs = '0;
      pred_valid = 1'b0; prediction = '0; fwd_ready = 1'b0; upd_ready = 1'b0;
      fwd_bp = 0; upd_bp = 0; lat_max = 0; junk_en = 1'b0;
      fwd_wait_cur = 0; upd_wait_cur = 0; fwd_cnt = 0; busy_cycles = 0;
      prev_ep = 0; prev_err = 0; outstanding = 1'b0;
      for (int s = 0; s < NUM; s++) tgt[s] = '0;
      set_plan_correct();
      #3;
      check_reset_zero("reset_state");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // AND set, always-correct predictions.
      tgt[0] = '0; tgt[1] = '0; tgt[2] = '0; tgt[3] = ONE;
      set_plan_correct();
      run_case("and_ok", 5, 0, 0, 0, 1'b0, 1'b1);

      // Sample 3 mispredicted in epoch 0 only.
      plan[0][3] = '0;
      run_case("and_miss3", 5, 0, 0, 0, 1'b0, 1'b1);

      // Zero epoch budget.
      run_case("epochs0", 0, 0, 0, 0, 1'b0, 1'b1);

      // Backpressure with a few mispredictions and stray pred_valid pulses.
      set_plan_correct();
      plan[0][1] = 32'h0000_8000; plan[1][3] = '0; plan[2][0] = 32'hFFFF_0000;
      run_case("backpressure", 3, 3, 2, 2, 1'b1, 1'b0);

      // XOR set, one mismatch every epoch.
      tgt[0] = '0; tgt[1] = ONE; tgt[2] = ONE; tgt[3] = '0;
      set_plan_correct();
      for (int e = 0; e < MAXE; e++) plan[e][e % NUM] = ONE - tgt[e % NUM];
      run_case("xor", 5, 0, 0, 0, 1'b0, 1'b1);

      // Reset during the UPDATE of epoch 2, then a fresh full run.
      tgt[0] = '0; tgt[1] = '0; tgt[2] = '0; tgt[3] = ONE;
      set_plan_correct();
      plan[0][0] = ONE; plan[1][0] = ONE; plan[2][1] = ONE;
      @(negedge clk); #1;
      prep(0, 0, 0, 1'b0);
      epochs = 16'd5;
      start  = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (upd_valid && fwd_cnt == 2 * NUM + 2) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      check_eq("rst_reached_update", {63'd0, hit}, 64'd1);
      check_eq("rst_update_pos", {sample_idx, epoch_count}, {2'd1, 16'd2});
      #1 rst_n = 1'b0;
      #1 check_reset_zero("rst_mid_update");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      run_case("after_reset", 5, 0, 0, 0, 1'b0, 1'b1);

      // Randomized training sets and plans.
      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < NUM; s++)
            tgt[s] = ($urandom_range(0, 1) == 0) ? '0 : $urandom;
         for (int e = 0; e < MAXE; e++)
            for (int s = 0; s < NUM; s++)
               plan[e][s] = ($urandom_range(0, 3) == 0) ? $urandom : tgt[s];
         run_case("random", int'($urandom_range(0, MAXE)), -1, -1, 3, 1'b1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
